// File: rtl/uart_rx_frame_collector.sv
// Collects ASCII decimal digits from a UART receiver into a packed BCD frame.
// A frame closes on N_DIGITS digits or on TERM; bad bytes and idle gaps abort it.
module uart_rx_frame_collector #(
  parameter int         N_DIGITS = 10,
  parameter int         TIMEOUT  = 1000000,
  parameter logic [7:0] TERM     = 8'h0D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [3:0]            frame_len,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int             BW         = 4 * N_DIGITS;
  localparam int             TW         = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]     FULL_LEN   = 4'(N_DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISCARD
  } state_t;

  state_t          state, state_n;
  logic [BW-1:0]   work, work_n;
  logic [3:0]      count, count_n;
  logic [TW-1:0]   timer, timer_n;
  logic [BW-1:0]   digits_n;
  logic [3:0]      frame_len_n;
  logic            done_n;
  logic            err_n;

  logic            is_digit;
  logic            is_term;
  logic            expired;
  logic [3:0]      nib;
  logic [3:0]      count_inc;
  logic [TW-1:0]   timer_tick;

  // A TERM value that happens to be a digit is treated as a digit.
  assign is_digit   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term    = (rx_data == TERM) && !is_digit;
  assign nib        = rx_data[3:0];
  assign count_inc  = count + 4'd1;
  // A byte arriving on the expiry cycle wins over the timeout.
  assign expired    = !rx_valid && (timer == TIMER_LAST);
  assign timer_tick = (timer == TIMER_LAST) ? timer : timer + TW'(1);

  // Writes a nibble at digit position pos, position 0 being the most significant.
  function automatic logic [BW-1:0] place(input logic [BW-1:0] frame_in,
                                          input logic [3:0]    pos,
                                          input logic [3:0]    val);
    logic [BW-1:0] r;
    r = frame_in;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (pos == 4'(i)) r[BW-4-4*i +: 4] = val;
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_n     = state;
    work_n      = work;
    count_n     = count;
    timer_n     = timer;
    digits_n    = digits;
    frame_len_n = frame_len;
    done_n      = 1'b0;
    err_n       = 1'b0;

    case (state)
      IDLE: begin
        timer_n = '0;
        if (rx_valid) begin
          if (is_digit) begin
            work_n  = place('0, 4'd0, nib);
            count_n = 4'd1;
            state_n = COLLECT;
          end else if (!is_term) begin
            err_n   = 1'b1;
            state_n = DISCARD;
          end
        end
      end

      COLLECT: begin
        if (rx_valid) begin
          timer_n = '0;
          if (is_digit) begin
            work_n  = place(work, count, nib);
            count_n = count_inc;
            if (count_inc == FULL_LEN) begin
              digits_n    = work_n;
              frame_len_n = FULL_LEN;
              done_n      = 1'b1;
              count_n     = '0;
              state_n     = IDLE;
            end
          end else if (is_term) begin
            digits_n    = work;
            frame_len_n = count;
            done_n      = 1'b1;
            count_n     = '0;
            state_n     = IDLE;
          end else begin
            err_n   = 1'b1;
            count_n = '0;
            state_n = DISCARD;
          end
        end else if (expired) begin
          err_n   = 1'b1;
          count_n = '0;
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer_tick;
        end
      end

      DISCARD: begin
        // Bytes are dropped silently; any byte still counts as line activity.
        if (rx_valid) begin
          timer_n = '0;
          if (is_term) state_n = IDLE;
        end else if (expired) begin
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer_tick;
        end
      end

      default: begin
        state_n = IDLE;
        count_n = '0;
        timer_n = '0;
      end
    endcase
  end

  // NOTE: the work buffer is a plain register bank, so it is reset along with the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      work       <= '0;
      count      <= '0;
      timer      <= '0;
      digits     <= '0;
      frame_len  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state      <= state_n;
      work       <= work_n;
      count      <= count_n;
      timer      <= timer_n;
      digits     <= digits_n;
      frame_len  <= frame_len_n;
      frame_done <= done_n;
      frame_err  <= err_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_collector.sv
// Directed bench for uart_rx_frame_collector with N_DIGITS=10, TIMEOUT=100, TERM=8'h0D.
module tb_uart_rx_frame_collector;

  localparam int N = 10;
  localparam int TO = 100;

  logic          clk;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [4*N-1:0] digits;
  logic [3:0]    frame_len;
  logic          frame_done;
  logic          frame_err;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  uart_rx_frame_collector #(
    .N_DIGITS(N),
    .TIMEOUT (TO),
    .TERM    (8'h0D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .digits    (digits),
    .frame_len (frame_len),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: each pulse is counted at the edge that ends its cycle.
  always @(posedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (frame_done && frame_err) both_cnt <= both_cnt + 1;
  end

  // Called at a falling edge; returns at the next falling edge, where the
  // registered response to this byte is visible.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    idle(3);
    checks++; if (digits !== '0) begin errors++; $display("FAIL reset_digits: got %h want 0", digits); end
    checks++; if (frame_len !== 4'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", frame_len); end
    checks++; if ({frame_done, frame_err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {frame_done, frame_err, busy}); end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_full_frame();
    logic [7:0] s [10] = '{"2","0","2","4","3","1","1","2","5","9"};
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 9; i++) begin
      send_byte(s[i]);
      idle(3);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_mid: got %b want 1", busy); end
    send_byte(s[9]);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL full_done_pulse: got %b want 1", frame_done); end
    checks++; if (digits !== 40'h2024311259) begin errors++; $display("FAIL full_digits: got %h want 2024311259", digits); end
    checks++; if (frame_len !== 4'd10) begin errors++; $display("FAIL full_len: got %0d want 10", frame_len); end
    idle(2);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL full_err_count: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_short_frame();
    send_byte("1"); send_byte("2"); send_byte("3");
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL short_early_done: got %b want 0", frame_done); end
    send_byte(8'h0D);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL short_done_pulse: got %b want 1", frame_done); end
    checks++; if (digits !== 40'h1230000000) begin errors++; $display("FAIL short_digits: got %h want 1230000000", digits); end
    checks++; if (frame_len !== 4'd3) begin errors++; $display("FAIL short_len: got %0d want 3", frame_len); end
    idle(2);
  endtask

  task automatic test_bad_char();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte("1"); send_byte("2"); send_byte("A");
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL bad_err_pulse: got %b want 1", frame_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bad_busy_discard: got %b want 1", busy); end
    send_byte("4"); send_byte("5"); send_byte(8'h0D);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_term_idle: got %b want 0", busy); end
    checks++; if (digits !== 40'h1230000000) begin errors++; $display("FAIL bad_digits_held: got %h want 1230000000", digits); end
    idle(2);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL bad_no_done: got %0d want 0", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL bad_err_count: got %0d want 1", err_cnt - e0); end
    send_byte("7"); send_byte(8'h0D);
    checks++; if (digits !== 40'h7000000000) begin errors++; $display("FAIL bad_next_digits: got %h want 7000000000", digits); end
    checks++; if (frame_len !== 4'd1) begin errors++; $display("FAIL bad_next_len: got %0d want 1", frame_len); end
    idle(2);
  endtask

  task automatic test_timeout();
    int e0;
    send_byte("9"); send_byte("8");
    idle(TO - 1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL to_early_err: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_before: got %b want 1", busy); end
    idle(1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL to_err_pulse: got %b want 1", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy_fall: got %b want 0", busy); end
    checks++; if (digits !== 40'h7000000000) begin errors++; $display("FAIL to_digits_held: got %h want 7000000000", digits); end
    send_byte("5"); send_byte(8'h0D);
    checks++; if (digits !== 40'h5000000000) begin errors++; $display("FAIL to_next_digits: got %h want 5000000000", digits); end
    idle(2);
    // Byte lands exactly on the expiry cycle.
    e0 = err_cnt;
    send_byte("9"); send_byte("8");
    idle(TO - 1);
    send_byte("3");
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL to_race_err: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_race_busy: got %b want 1", busy); end
    send_byte(8'h0D);
    checks++; if (digits !== 40'h9830000000) begin errors++; $display("FAIL to_race_digits: got %h want 9830000000", digits); end
    checks++; if (frame_len !== 4'd3) begin errors++; $display("FAIL to_race_len: got %0d want 3", frame_len); end
    idle(2);
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL to_race_err_count: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_discard_timeout();
    int e0, d0;
    e0 = err_cnt; d0 = done_cnt;
    send_byte("X");
    idle(TO - 1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL disc_busy_before: got %b want 1", busy); end
    idle(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL disc_busy_fall: got %b want 0", busy); end
    idle(2);
    checks++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin errors++; $display("FAIL disc_pulses: got err=%0d done=%0d want err=1 done=0", err_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int e0, d0;
    e0 = err_cnt; d0 = done_cnt;
    send_byte("3"); send_byte("1");
    rst = 1'b0;
    #1;
    checks++; if (digits !== '0 || frame_len !== 4'd0) begin errors++; $display("FAIL rmid_data_zero: got %h/%0d want 0/0", digits, frame_len); end
    checks++; if ({frame_done, frame_err, busy} !== 3'b000) begin errors++; $display("FAIL rmid_flags_zero: got %b want 000", {frame_done, frame_err, busy}); end
    idle(2);
    rst = 1'b1;
    idle(2);
    checks++; if (err_cnt - e0 !== 0 || done_cnt - d0 !== 0) begin errors++; $display("FAIL rmid_no_pulse: got err=%0d done=%0d want 0", err_cnt - e0, done_cnt - d0); end
    send_byte("4"); send_byte(8'h0D);
    checks++; if (digits !== 40'h4000000000) begin errors++; $display("FAIL rmid_digits: got %h want 4000000000", digits); end
    checks++; if (frame_len !== 4'd1) begin errors++; $display("FAIL rmid_len: got %0d want 1", frame_len); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [11] = '{"1","2","3","4","5","6","7","8","9","0","1"};
    int e0, d0;
    e0 = err_cnt; d0 = done_cnt;
    send_byte(8'h0D);
    checks++; if ({frame_done, frame_err, busy} !== 3'b000) begin errors++; $display("FAIL lone_term: got %b want 000", {frame_done, frame_err, busy}); end
    for (int i = 0; i < 10; i++) send_byte(s[i]);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_done_10th: got %b want 1", frame_done); end
    checks++; if (digits !== 40'h1234567890) begin errors++; $display("FAIL b2b_digits: got %h want 1234567890", digits); end
    send_byte(s[10]);
    checks++; if (frame_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_11th: got done=%b busy=%b want done=0 busy=1", frame_done, busy); end
    checks++; if (digits !== 40'h1234567890 || frame_len !== 4'd10) begin errors++; $display("FAIL b2b_held: got %h/%0d want 1234567890/10", digits, frame_len); end
    send_byte(8'h0D);
    checks++; if (digits !== 40'h1000000000 || frame_len !== 4'd1) begin errors++; $display("FAIL b2b_next: got %h/%0d want 1000000000/1", digits, frame_len); end
    idle(2);
    checks++; if (done_cnt - d0 !== 2 || err_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_counts: got done=%0d err=%0d want done=2 err=0", done_cnt - d0, err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_bad_char();
    test_timeout();
    test_discard_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_collector.md
Name: uart_rx_frame_collector

Overview:
Receive-side counterpart of the UART transmit data sequencer. It sits after the UART receiver and takes one byte per rx_valid pulse. It assembles a frame of ASCII decimal digits into a packed BCD register for the display path. It also reports frame completion and frame errors (bad character, inter-byte timeout).

Parameters:
N_DIGITS, 10, digits per full frame; legal range 2..15.
TIMEOUT, 1000000, idle clk cycles allowed between bytes inside a frame before the frame is aborted; must be at least 2.
TERM, 8'h0D, terminator byte that closes a short frame.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
rx_data  input  8  received byte.
digits  output  4*N_DIGITS  last completed frame, packed BCD. First received digit is in digits[4*N_DIGITS-1 -: 4]; unused low nibbles are 0.
frame_len  output  4  number of digits in the last completed frame.
frame_done  output  1  one-cycle pulse: digits and frame_len were just updated.
frame_err  output  1  one-cycle pulse: the current frame was aborted.
busy  output  1  high while in COLLECT or DISCARD.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; work buffer, count and timer are cleared.
  - digits=0, frame_len=0, frame_done=0, frame_err=0, busy=0.
  - Reset mid-frame drops the partial frame with no pulse.
- Digit definition: rx_data in 8'h30..8'h39; the nibble value is rx_data[3:0].
- All outputs are registered. Each pulse appears in the cycle after the clk edge that sampled the causing rx_valid or timeout.
- State IDLE:
  - rx_valid with a digit: clear the work buffer, store the digit at position 0, count=1, timer=0, go to COLLECT.
  - rx_valid with TERM: ignore; empty frames produce no pulse.
  - rx_valid with any other byte: pulse frame_err, go to DISCARD.
- State COLLECT:
  - Digit received: store it at position count, count+1, timer=0.
    - If the new count equals N_DIGITS: copy the buffer to digits, set frame_len=N_DIGITS, pulse frame_done, go to IDLE. No TERM is needed.
  - TERM received: copy the buffer to digits, set frame_len=count, pulse frame_done, go to IDLE.
  - Other byte received: pulse frame_err, go to DISCARD. digits and frame_len are unchanged.
  - No rx_valid: timer+1. When the timer reaches TIMEOUT-1, pulse frame_err, go to IDLE, clear count.
- State DISCARD:
  - Every byte is dropped. TERM returns the block to IDLE with no pulse.
  - The timeout runs here too and returns to IDLE with no pulse.
- Simultaneous events:
  - rx_valid in the same cycle the timer would expire: the byte wins and the timer restarts.
  - frame_done and frame_err are never asserted in the same cycle.
- digits and frame_len hold their value until the next frame_done.
- Bytes arriving while a pulse is high are processed normally; there is no dead cycle.
- A digit following a full N_DIGITS frame starts a new frame.
- Timer width: enough to hold TIMEOUT-1. The timer saturates and does not wrap.

Test Plan:
1. Full frame, N_DIGITS=10: send "2024311259" with gaps of 3 cycles.
   -> Exactly one frame_done, in the cycle after the 10th byte.
   -> digits=40'h2024311259, frame_len=10, frame_err never asserted.
2. Short frame: send "123" then 8'h0D.
   -> digits=40'h1230000000, frame_len=3, frame_done pulse after the TERM byte.
3. Bad character: send "12A45" then 8'h0D, then "7" then 8'h0D.
   -> frame_err pulse after 'A'; no frame_done for the first frame; digits unchanged.
   -> Second frame gives digits=40'h7000000000, frame_len=1.
4. Timeout, bench TIMEOUT=100: send "98", then no rx_valid.
   -> frame_err pulse 100 cycles after '8'; busy falls; digits unchanged.
   -> Then "5" and 8'h0D gives digits=40'h5000000000.
   -> Re-run with rx_valid exactly on the expiry cycle: no frame_err.
5. Reset mid-frame: send "31", pull rst low for 2 cycles, release, then send "4" and 8'h0D.
   -> All outputs are 0 during reset; no pulses occur.
   -> Then digits=40'h4000000000, frame_len=1.
6. Edge cases:
   - Lone 8'h0D in IDLE -> no pulse.
   - 11 back-to-back digits -> frame_done after the 10th; the 11th leaves busy=1 with a new frame open.
